// File: rtl/zone_alarm_pkg.sv
// Shared types and constants for the multi-zone alarm controller.
// Holds the FSM encoding and the counter-width helper.
package zone_alarm_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      DISARMED    = 3'd0,
      EXIT_DELAY  = 3'd1,
      ARMED       = 3'd2,
      ENTRY_DELAY = 3'd3,
      ALARM       = 3'd4
   } state_t;

   // Width of the shared down-counter: enough for the longest delay, plus one bit.
   function automatic int calc_cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/alarm_sync.sv
// Two-flop synchroniser for the raw zone sensor levels.
// Both stages clear to 0 on reset.
module alarm_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_reg;
   logic [W-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/zone_alarm_ctrl.sv
// Multi-zone intruder alarm: arm/disarm FSM with exit and entry delays,
// timed siren and latched trip memory. Every output is a flop.
module zone_alarm_ctrl
   import zone_alarm_pkg::*;
#(
   parameter int N_ZONES      = 3,
   parameter int EXIT_CYCLES  = 16,
   parameter int ENTRY_CYCLES = 8,
   parameter int SIREN_CYCLES = 32,
   parameter int CNT_W        = calc_cnt_w(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_ZONES-1:0] zone_in,
   input  logic [N_ZONES-1:0] bypass,
   input  logic [N_ZONES-1:0] instant,
   input  logic               arm,
   input  logic               disarm,
   output logic               siren,
   output logic               armed,
   output logic               pending,
   output logic [STATE_W-1:0] state,
   output logic [N_ZONES-1:0] zone_mem,
   output logic               arm_err
);

   localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

   // Reset asserts immediately but releases only on a clock edge.
   logic rst_meta_reg, rst_sync_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_reg <= 1'b0;
         rst_sync_n   <= 1'b0;
      end else begin
         rst_meta_reg <= 1'b1;
         rst_sync_n   <= rst_meta_reg;
      end
   end

   logic [N_ZONES-1:0] zone_s;

   alarm_sync #(.W(N_ZONES)) u_sync (
      .clk   (clk),
      .rst_n (rst_sync_n),
      .d     (zone_in),
      .q     (zone_s)
   );

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_dec;
   logic [N_ZONES-1:0] bypass_reg, bypass_next;
   logic [N_ZONES-1:0] instant_reg, instant_next;
   logic [N_ZONES-1:0] zone_mem_reg, zone_mem_next;
   logic               siren_reg, siren_next;
   logic               armed_reg, armed_next;
   logic               pending_reg, pending_next;
   logic               arm_err_reg, arm_err_next;
   logic [N_ZONES-1:0] active;
   logic               any_active, any_instant;

   assign active      = zone_s & ~bypass_reg;
   assign any_active  = |active;
   assign any_instant = |(active & instant_reg);
   assign cnt_dec     = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bypass_next   = bypass_reg;
      instant_next  = instant_reg;
      zone_mem_next = zone_mem_reg;
      siren_next    = siren_reg;
      arm_err_next  = 1'b0;

      if (disarm) begin
         state_next = DISARMED;
         siren_next = 1'b0;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            DISARMED: begin
               siren_next = 1'b0;
               if (arm) begin
                  // Arming checks the live bypass mask, not the latched one.
                  if (|(zone_s & ~bypass)) begin
                     arm_err_next = 1'b1;
                  end else begin
                     state_next    = EXIT_DELAY;
                     bypass_next   = bypass;
                     instant_next  = instant;
                     cnt_next      = EXIT_LOAD;
                     zone_mem_next = '0;
                  end
               end
            end
            EXIT_DELAY: begin
               if (cnt_reg == '0) state_next = ARMED;
               else               cnt_next   = cnt_dec;
            end
            ARMED: begin
               zone_mem_next = zone_mem_reg | active;
               if (any_instant) begin
                  state_next = ALARM;
                  cnt_next   = SIREN_LOAD;
                  siren_next = 1'b1;
               end else if (any_active) begin
                  state_next = ENTRY_DELAY;
                  cnt_next   = ENTRY_LOAD;
               end
            end
            ENTRY_DELAY: begin
               zone_mem_next = zone_mem_reg | active;
               if (any_instant || cnt_reg == '0) begin
                  state_next = ALARM;
                  cnt_next   = SIREN_LOAD;
                  siren_next = 1'b1;
               end else begin
                  cnt_next = cnt_dec;
               end
            end
            ALARM: begin
               // Siren runs out once and stays silent until disarmed.
               zone_mem_next = zone_mem_reg | active;
               siren_next    = siren_reg && (cnt_reg != '0);
               cnt_next      = cnt_dec;
            end
            default: begin
               state_next = DISARMED;
               siren_next = 1'b0;
               cnt_next   = '0;
            end
         endcase
      end

      armed_next   = (state_next == ARMED) || (state_next == ENTRY_DELAY) ||
                     (state_next == ALARM);
      pending_next = (state_next == EXIT_DELAY) || (state_next == ENTRY_DELAY);
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_reg    <= DISARMED;
         cnt_reg      <= '0;
         bypass_reg   <= '0;
         instant_reg  <= '0;
         zone_mem_reg <= '0;
         siren_reg    <= 1'b0;
         armed_reg    <= 1'b0;
         pending_reg  <= 1'b0;
         arm_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bypass_reg   <= bypass_next;
         instant_reg  <= instant_next;
         zone_mem_reg <= zone_mem_next;
         siren_reg    <= siren_next;
         armed_reg    <= armed_next;
         pending_reg  <= pending_next;
         arm_err_reg  <= arm_err_next;
      end
   end

   assign state    = state_reg;
   assign siren    = siren_reg;
   assign armed    = armed_reg;
   assign pending  = pending_reg;
   assign zone_mem = zone_mem_reg;
   assign arm_err  = arm_err_reg;

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// Directed bench for zone_alarm_ctrl with hand-computed expectations
// for the default parameter set (3 zones, 16/8/32 cycles).
module tb_zone_alarm_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] zone_in, bypass, instant;
   logic       arm, disarm;
   logic       siren, armed, pending, arm_err;
   logic [2:0] state, zone_mem;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   zone_alarm_ctrl #(
      .N_ZONES      (3),
      .EXIT_CYCLES  (16),
      .ENTRY_CYCLES (8),
      .SIREN_CYCLES (32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .zone_in  (zone_in),
      .bypass   (bypass),
      .instant  (instant),
      .arm      (arm),
      .disarm   (disarm),
      .siren    (siren),
      .armed    (armed),
      .pending  (pending),
      .state    (state),
      .zone_mem (zone_mem),
      .arm_err  (arm_err)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("chk  %s: got %0h", tag, got);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic arm_seq(input logic [2:0] byp, input logic [2:0] inst);
      bypass  = byp;
      instant = inst;
      arm     = 1'b1;
      tick();
      arm     = 1'b0;
      check_value("arm_seq_exit", state, 3'd1);
      tick(16);
      check_value("arm_seq_armed", state, 3'd2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; zone_in = '0; bypass = '0; instant = '0; arm = 1'b0; disarm = 1'b0;
      tick(3);
      check_value("rst_siren",    siren,    1'b0);
      check_value("rst_armed",    armed,    1'b0);
      check_value("rst_pending",  pending,  1'b0);
      check_value("rst_state",    state,    3'd0);
      check_value("rst_zone_mem", zone_mem, 3'b000);
      check_value("rst_arm_err",  arm_err,  1'b0);
      rst_n   = 1'b1;
      zone_in = 3'b010;
      tick(4);

      // Arm rejected by a tripped unbypassed zone; held arm keeps pulsing.
      arm = 1'b1;
      tick();
      check_value("rej_arm_err", arm_err, 1'b1);
      check_value("rej_state",   state,   3'd0);
      tick();
      check_value("rej_held_arm_err", arm_err, 1'b1);
      arm = 1'b0;
      tick();
      check_value("rej_arm_err_clr", arm_err, 1'b0);

      // Same zone bypassed: exit delay of exactly 16 cycles.
      bypass = 3'b010;
      arm    = 1'b1;
      tick();
      arm = 1'b0;
      check_value("exit_state",   state,   3'd1);
      check_value("exit_pending", pending, 1'b1);
      check_value("exit_armed",   armed,   1'b0);
      tick(15);
      check_value("exit_last_cycle", state, 3'd1);
      tick();
      check_value("armed_state",   state,   3'd2);
      check_value("armed_armed",   armed,   1'b1);
      check_value("armed_pending", pending, 1'b0);
      bypass = 3'b000;
      tick(3);
      check_value("bypass_latched", state, 3'd2);

      // Delayed zone: entry delay 8 cycles, then siren for 32 cycles.
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      check_value("disarm_state", state, 3'd0);
      zone_in = 3'b000;
      tick(2);
      arm_seq(3'b000, 3'b000);
      zone_in = 3'b010;
      tick(2);
      check_value("sync_edge2", state, 3'd2);
      tick();
      check_value("entry_state",   state,   3'd3);
      check_value("entry_pending", pending, 1'b1);
      check_value("entry_siren",   siren,   1'b0);
      tick(7);
      check_value("entry_last_cycle", state, 3'd3);
      tick();
      check_value("alarm_state", state, 3'd4);
      check_value("alarm_siren", siren, 1'b1);
      check_value("alarm_zmem",  zone_mem, 3'b010);
      tick(31);
      check_value("siren_last_cycle", siren, 1'b1);
      tick();
      check_value("siren_off",      siren,    1'b0);
      check_value("silent_state",   state,    3'd4);
      check_value("silent_armed",   armed,    1'b1);
      check_value("silent_zmem",    zone_mem, 3'b010);
      tick(4);
      check_value("no_retrigger", siren, 1'b0);

      // Instant zone goes straight to ALARM; zone joining the alarm is recorded.
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      check_value("disarm2_state", state,    3'd0);
      check_value("disarm2_zmem",  zone_mem, 3'b010);
      check_value("disarm2_siren", siren,    1'b0);
      zone_in = 3'b000;
      tick(2);
      arm_seq(3'b000, 3'b001);
      check_value("arm_clears_zmem", zone_mem, 3'b000);
      zone_in = 3'b001;
      tick(2);
      check_value("inst_edge2", state, 3'd2);
      tick();
      check_value("inst_alarm_state", state,    3'd4);
      check_value("inst_siren",       siren,    1'b1);
      check_value("inst_zmem",        zone_mem, 3'b001);
      zone_in = 3'b101;
      tick(3);
      check_value("join_zmem", zone_mem, 3'b101);

      // Asynchronous reset in the middle of ALARM.
      #2;
      rst_n = 1'b0;
      #1;
      check_value("async_rst_siren", siren,    1'b0);
      check_value("async_rst_state", state,    3'd0);
      check_value("async_rst_zmem",  zone_mem, 3'b000);
      check_value("async_rst_armed", armed,    1'b0);
      tick();
      rst_n   = 1'b1;
      zone_in = 3'b000;
      tick(4);

      // Disarm during the entry delay keeps the trip memory.
      arm_seq(3'b000, 3'b000);
      zone_in = 3'b010;
      tick(3);
      check_value("entry2_state", state, 3'd3);
      tick(4);
      check_value("entry2_cycle5", state, 3'd3);
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      check_value("entry_disarm_state", state,    3'd0);
      check_value("entry_disarm_siren", siren,    1'b0);
      check_value("entry_disarm_zmem",  zone_mem, 3'b010);
      zone_in = 3'b000;
      tick(2);
      arm = 1'b1;
      tick();
      check_value("rearm_zmem",  zone_mem, 3'b000);
      check_value("rearm_state", state,    3'd1);

      // arm together with disarm: disarm wins in EXIT_DELAY and in DISARMED.
      disarm = 1'b1;
      tick();
      check_value("both_exit_state", state, 3'd0);
      arm = 1'b0; disarm = 1'b0;
      zone_in = 3'b010;
      tick(2);
      arm = 1'b1; disarm = 1'b1;
      tick();
      check_value("both_dis_state",   state,   3'd0);
      check_value("both_dis_arm_err", arm_err, 1'b0);
      arm = 1'b0; disarm = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/zone_alarm_ctrl.md
Name: zone_alarm_ctrl

Overview:
Parametrised multi-zone intruder alarm controller. It generalises the combinational motion/door/window alarm into a clocked system:
- N sensor zones with per-zone bypass and instant/delayed modes
- arm/disarm control with exit and entry delays
- timed siren and latched trip memory

It sits behind the top-level pin wrapper: zones come from ui_in, control from uio_in, status goes to uo_out.

Parameters:
N_ZONES, 3, number of sensor zones (1..8)
EXIT_CYCLES, 16, exit-delay length in clk cycles (>=1)
ENTRY_CYCLES, 8, entry-delay length in clk cycles (>=1)
SIREN_CYCLES, 32, siren-on duration in clk cycles (>=1)
CNT_W, $clog2(max of the three cycle parameters)+1, shared down-counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
zone_in  in  N_ZONES  raw sensor levels, 1 = tripped, asynchronous to clk
bypass  in  N_ZONES  1 = zone excluded; sampled only when arm is accepted
instant  in  N_ZONES  1 = zone skips entry delay; sampled only when arm is accepted
arm  in  1  synchronous request pulse/level, evaluated each cycle
disarm  in  1  synchronous request, evaluated each cycle
siren  out  1  alarm sounder drive
armed  out  1  1 in ARMED, ENTRY_DELAY or ALARM
pending  out  1  1 in EXIT_DELAY or ENTRY_DELAY
state  out  3  current FSM encoding
zone_mem  out  N_ZONES  zones that caused or joined an alarm since last accepted arm
arm_err  out  1  one-cycle pulse: arm rejected because an unbypassed zone was tripped

Behaviour:
- Reset (async assert, sync deassert via flops on clk):
  - state = DISARMED; all outputs 0
  - counter 0; bypass_q/instant_q 0; synchroniser flops 0
- Synchronisation: zone_in passes a 2-flop synchroniser. zone_s is valid 2 edges after the input changes; the FSM reacts on the following edge.
- active = zone_s & ~bypass_q.
- All outputs are registered. state output = state register; no combinational path from any input to any output.
- State encodings: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Unused codes 5-7 go to DISARMED on the next edge.
- disarm has priority over arm and over every zone event in every state: next state DISARMED, siren 0, counter 0, zone_mem held.
- DISARMED:
  - arm=1 and (zone_s & ~bypass)==0 -> EXIT_DELAY. Latch bypass_q<=bypass and instant_q<=instant; counter<=EXIT_CYCLES-1; zone_mem<=0.
  - arm=1 with any unbypassed zone tripped -> stay, arm_err=1 for exactly one cycle. Held arm re-pulses arm_err every cycle.
- EXIT_DELAY: zones ignored; counter decrements each cycle; at counter==0 -> ARMED. Dwell is exactly EXIT_CYCLES cycles.
- ARMED:
  - any active & instant_q -> ALARM, counter<=SIREN_CYCLES-1
  - else any active -> ENTRY_DELAY, counter<=ENTRY_CYCLES-1
  - zone_mem |= active on the transition edge
- ENTRY_DELAY:
  - counter decrements; zone_mem |= active each cycle
  - any active & instant_q -> ALARM immediately
  - counter==0 -> ALARM, counter<=SIREN_CYCLES-1
- ALARM:
  - siren=1 while counter runs; counter decrements to 0; siren goes 0 on the edge after counter reaches 0
  - remains in ALARM (silent, armed=1) until disarm
  - zone_mem |= active every cycle
  - does not retrigger the siren
- arm while not DISARMED: ignored, no arm_err.
- Siren timing: siren rises on the same edge that enters ALARM and is high for exactly SIREN_CYCLES cycles.
- Counter never wraps; it saturates at 0.
- Reset mid-operation: immediate return to reset values, including zone_mem.

Decomposition:
- Package zone_alarm_pkg:
  - state enum/localparams (DISARMED..ALARM, 3-bit)
  - state width constant
  - function computing CNT_W from the three cycle parameters
- Sub-module alarm_sync: parametrised-width 2-flop synchroniser, async active-low reset to 0. Instantiated once with width N_ZONES.
- FSM, counter and output registers stay in zone_alarm_ctrl.

Test Plan:
- Reset with all inputs 0 -> siren=0, armed=0, pending=0, state=0, zone_mem=000, arm_err=0. Assert rst_n=0 mid-ALARM -> all outputs 0 asynchronously, before the next clk edge.
- zone_in=010, bypass=000, arm pulse -> arm_err=1 for one cycle, state=0. Repeat with bypass=010 -> state=1, pending=1 for 16 cycles, then state=2, armed=1, pending=0.
- Armed, instant=000, zone_in[1] rises -> state=3 on the 3rd edge after the input change. No disarm for 8 cycles -> state=4, siren=1 for 32 cycles, then siren=0 with state=4 held; zone_mem=010.
- Armed, instant=001, zone_in[0] rises -> state goes directly 2->4 on the 3rd edge, siren=1, zone_mem=001. zone_in[2] trips during ALARM -> zone_mem=101.
- ENTRY_DELAY entered, disarm asserted on the 5th cycle -> state=0, siren stays 0, zone_mem keeps value. Then arm with zones clear -> zone_mem cleared to 000.
- arm and disarm both asserted in DISARMED -> state stays 0, arm_err=0. Both asserted in EXIT_DELAY -> state=0 next edge.
